stroke_draw_scheduler: RTL and testbench

Sequences the line-drawing datapath for the paint pipeline. It accepts a stream of tracked pen points, turns each consecutive pair within a stroke into one segment job for the line drawer, and paces the drawer's enable, end_frame and renew pulses. It forwards every drawn position, after range filtering and de-duplication, to the frame-buffer pixel writer over a valid/ready handshake. The block sits between the point tracker and the SRAM write port, which owns the drawer instance.

---
 rtl/stroke_draw_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_stroke_draw_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_draw_scheduler.sv
// Stroke draw scheduler: turns tracked pen points into line-drawer segment jobs,
// paces the drawer's load/start/advance pulses and forwards range-filtered,
// de-duplicated pixel positions to the frame-buffer writer.
module stroke_draw_scheduler #(
  parameter int X_MAX     = 799,
  parameter int Y_MAX     = 599,
  parameter int MAX_STEPS = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [9:0]  pt_x,
  input  logic [9:0]  pt_y,
  input  logic        pt_new_stroke,
  input  logic [3:0]  cfg_point_size,
  input  logic        abort,
  output logic        dl_enable,
  output logic        dl_end_frame,
  output logic        dl_renew,
  output logic        dl_different_line,
  output logic [3:0]  dl_point_size,
  output logic [9:0]  dl_x1,
  output logic [9:0]  dl_y1,
  output logic [9:0]  dl_x2,
  output logic [9:0]  dl_y2,
  input  logic [9:0]  dl_x,
  input  logic [9:0]  dl_y,
  input  logic        dl_done,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        busy,
  output logic [15:0] seg_count,
  output logic [15:0] drop_count,
  output logic        timeout_err
);

  localparam logic [9:0] X_LIM    = 10'(X_MAX);
  localparam logic [9:0] Y_LIM    = 10'(Y_MAX);
  localparam logic [9:0] STEP_LIM = 10'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    RENEW   = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t state, next_state;

  logic       ready_en;
  logic       have_prev;
  logic [9:0] prev_x, prev_y;
  logic [9:0] step_cnt;
  logic       done_r;
  logic       last_valid;
  logic [9:0] last_x, last_y;

  logic in_range, is_dup, write_pix, at_limit, accept;

  assign in_range  = (dl_x <= X_LIM) && (dl_y <= Y_LIM);
  assign is_dup    = last_valid && (dl_x == last_x) && (dl_y == last_y);
  assign write_pix = in_range && !is_dup;
  assign at_limit  = (step_cnt == STEP_LIM);
  assign accept    = pt_valid && pt_ready;
  assign busy      = (state != IDLE);

  // State register; reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and pulse outputs; abort forces IDLE and silences every pulse.
  always_comb begin
    next_state   = state;
    pt_ready     = 1'b0;
    dl_enable    = 1'b0;
    dl_end_frame = 1'b0;
    dl_renew     = 1'b0;
    px_valid     = 1'b0;
    case (state)
      IDLE: begin
        pt_ready = ready_en && !abort;
        if (pt_valid && ready_en && !abort) next_state = LOAD;
      end
      LOAD: begin
        dl_enable  = 1'b1;
        next_state = START;
      end
      START: begin
        dl_end_frame = 1'b1;
        next_state   = CAPTURE;
      end
      CAPTURE: begin
        if (write_pix)                next_state = WRITE;
        else if (dl_done || at_limit) next_state = FINISH;
        else                          next_state = RENEW;
      end
      WRITE: begin
        px_valid = 1'b1;
        if (px_ready) next_state = (done_r || at_limit) ? FINISH : RENEW;
      end
      RENEW: begin
        dl_renew   = 1'b1;
        next_state = CAPTURE;
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state   = IDLE;
      dl_enable    = 1'b0;
      dl_end_frame = 1'b0;
      dl_renew     = 1'b0;
      px_valid     = 1'b0;
    end
  end

  // Hold pt_ready low until the first clock after reset is released.
  always_ff @(posedge clk) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // Latch segment endpoints and brush size when a point is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_x1             <= '0;
      dl_y1             <= '0;
      dl_x2             <= '0;
      dl_y2             <= '0;
      dl_point_size     <= '0;
      dl_different_line <= 1'b0;
    end else if (accept) begin
      dl_x2         <= pt_x;
      dl_y2         <= pt_y;
      dl_point_size <= cfg_point_size;
      if (!have_prev || pt_new_stroke) begin
        dl_x1             <= pt_x;
        dl_y1             <= pt_y;
        dl_different_line <= 1'b1;
      end else begin
        dl_x1             <= prev_x;
        dl_y1             <= prev_y;
        dl_different_line <= 1'b0;
      end
    end
  end

  // Remember the end of the last finished segment; abort breaks the stroke.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
      prev_x    <= '0;
      prev_y    <= '0;
    end else if (abort) begin
      have_prev <= 1'b0;
    end else if (state == FINISH) begin
      have_prev <= 1'b1;
      prev_x    <= dl_x2;
      prev_y    <= dl_y2;
    end
  end

  // Per-segment datapath: step counter, captured drawer state, last emitted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt   <= '0;
      done_r     <= 1'b0;
      last_valid <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      px_x       <= '0;
      px_y       <= '0;
    end else if (!abort) begin
      case (state)
        START: begin
          step_cnt   <= '0;
          last_valid <= 1'b0;
        end
        CAPTURE: begin
          done_r <= dl_done;
          if (write_pix) begin
            px_x       <= dl_x;
            px_y       <= dl_y;
            last_x     <= dl_x;
            last_y     <= dl_y;
            last_valid <= 1'b1;
          end
        end
        RENEW: begin
          if (!at_limit) step_cnt <= step_cnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Status counters and the sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_count   <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else if (!abort) begin
      if (state == FINISH) begin
        seg_count <= seg_count + 16'd1;
        if (at_limit && !done_r) timeout_err <= 1'b1;
      end
      if (state == CAPTURE && !in_range && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_stroke_draw_scheduler.sv
// Self-checking bench for stroke_draw_scheduler with a scripted line-drawer stub.
module tb_stroke_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pt_valid, pt_ready;
  logic [9:0]  pt_x, pt_y;
  logic        pt_new_stroke;
  logic [3:0]  cfg_point_size;
  logic        abort;
  logic        dl_enable, dl_end_frame, dl_renew, dl_different_line;
  logic [3:0]  dl_point_size;
  logic [9:0]  dl_x1, dl_y1, dl_x2, dl_y2;
  logic [9:0]  dl_x, dl_y;
  logic        dl_done;
  logic        px_valid, px_ready;
  logic [9:0]  px_x, px_y;
  logic        busy;
  logic [15:0] seg_count, drop_count;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Drawer stub: a scripted path, restarted by dl_end_frame, advanced by dl_renew.
  logic [9:0] path_x [32];
  logic [9:0] path_y [32];
  logic       path_done [32];
  int         idx;

  // Monitor bookkeeping, written only by the monitor process.
  logic [19:0] pix_q [$];
  int          renew_cnt   = 0;
  int          overlap_cnt = 0;

  always #5 clk = ~clk;

  stroke_draw_scheduler #(.X_MAX(799), .Y_MAX(599), .MAX_STEPS(8)) dut (
    .clk(clk), .rst(rst),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .pt_new_stroke(pt_new_stroke), .cfg_point_size(cfg_point_size), .abort(abort),
    .dl_enable(dl_enable), .dl_end_frame(dl_end_frame), .dl_renew(dl_renew),
    .dl_different_line(dl_different_line), .dl_point_size(dl_point_size),
    .dl_x1(dl_x1), .dl_y1(dl_y1), .dl_x2(dl_x2), .dl_y2(dl_y2),
    .dl_x(dl_x), .dl_y(dl_y), .dl_done(dl_done),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .busy(busy), .seg_count(seg_count), .drop_count(drop_count), .timeout_err(timeout_err)
  );

  // Stub position index follows the drawer control pulses.
  always @(posedge clk) begin
    if (rst)                         idx <= 0;
    else if (dl_end_frame)           idx <= 0;
    else if (dl_renew && idx < 31)   idx <= idx + 1;
  end

  // Stub outputs come straight from the scripted path.
  always_comb begin
    dl_x    = path_x[idx];
    dl_y    = path_y[idx];
    dl_done = path_done[idx];
  end

  // Record handshaked pixels, renew pulses and any overlapping drawer pulses.
  always @(posedge clk) begin
    if (px_valid && px_ready) pix_q.push_back({px_x, px_y});
    if (dl_renew) renew_cnt++;
    if ((int'(dl_enable) + int'(dl_end_frame) + int'(dl_renew)) > 1) overlap_cnt++;
  end

  typedef struct {
    logic [9:0] x, y;
    logic       ns;
    logic [3:0] size;
    logic [9:0] ex1, ey1;
    logic       ediff;
    int         enpx;
    int         ewait;
    int         edrop;
  } row_t;

  row_t rows [6];
  int   exp_seg  = 0;
  int   exp_drop = 0;

  function automatic logic [19:0] pix(input logic [9:0] x, input logic [9:0] y);
    return {x, y};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_path();
    for (int i = 0; i < 32; i++) begin
      path_x[i]    = '0;
      path_y[i]    = '0;
      path_done[i] = 1'b0;
    end
  endtask

  task automatic set_single(input logic [9:0] x, input logic [9:0] y);
    clear_path();
    path_x[0]    = x;
    path_y[0]    = y;
    path_done[0] = 1'b1;
  endtask

  // Present a point and return right after the accepting edge.
  task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y,
                                input logic ns, input logic [3:0] size);
    int n;
    @(negedge clk);
    pt_x = x; pt_y = y; pt_new_stroke = ns; cfg_point_size = size;
    pt_valid = 1'b1;
    n = 0;
    while (!pt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("pt_ready_wait", 32'(pt_ready), 32'd1);
    @(posedge clk);
    #1 pt_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check_output("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_px_valid(input string name, input int want_q);
    int n;
    n = 0;
    while (!(px_valid && pix_q.size() == want_q) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(px_valid), 32'd1);
  endtask

  initial begin
    int n, base, r0;

    rows[0] = '{10'd100, 10'd50,  1'b1, 4'd3,  10'd100, 10'd50,  1'b1, 1, 4, 0};
    rows[1] = '{10'd120, 10'd60,  1'b0, 4'd5,  10'd100, 10'd50,  1'b0, 1, 4, 0};
    rows[2] = '{10'd130, 10'd70,  1'b1, 4'd2,  10'd130, 10'd70,  1'b1, 1, 4, 0};
    rows[3] = '{10'd805, 10'd10,  1'b0, 4'd1,  10'd130, 10'd70,  1'b0, 0, 3, 1};
    rows[4] = '{10'd799, 10'd599, 1'b0, 4'd15, 10'd805, 10'd10,  1'b0, 1, 4, 1};
    rows[5] = '{10'd0,   10'd600, 1'b0, 4'd0,  10'd799, 10'd599, 1'b0, 0, 3, 2};

    rst = 1'b1; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_new_stroke = 1'b0;
    cfg_point_size = '0; abort = 1'b0; px_ready = 1'b1;
    clear_path();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_pt_ready", 32'(pt_ready), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_seg", 32'(seg_count), 32'd0);
    check_output("rst_drop", 32'(drop_count), 32'd0);
    check_output("rst_timeout", 32'(timeout_err), 32'd0);
    check_output("rst_px_valid", 32'(px_valid), 32'd0);
    check_output("rst_dl_x1", 32'(dl_x1), 32'd0);
    rst = 1'b0;
    #1 check_output("rel_pt_ready_low", 32'(pt_ready), 32'd0);
    @(negedge clk);
    check_output("rel_pt_ready_high", 32'(pt_ready), 32'd1);

    // Table of single-pixel segments: endpoint selection, filter, latency.
    for (int i = 0; i < 6; i++) begin
      set_single(rows[i].x, rows[i].y);
      base = pix_q.size();
      apply_stimulus(rows[i].x, rows[i].y, rows[i].ns, rows[i].size);
      @(negedge clk);
      check_output($sformatf("r%0d_enable", i), 32'(dl_enable), 32'd1);
      check_output($sformatf("r%0d_pt_ready", i), 32'(pt_ready), 32'd0);
      check_output($sformatf("r%0d_x1", i), 32'(dl_x1), 32'(rows[i].ex1));
      check_output($sformatf("r%0d_y1", i), 32'(dl_y1), 32'(rows[i].ey1));
      check_output($sformatf("r%0d_x2", i), 32'(dl_x2), 32'(rows[i].x));
      check_output($sformatf("r%0d_y2", i), 32'(dl_y2), 32'(rows[i].y));
      check_output($sformatf("r%0d_diff", i), 32'(dl_different_line), 32'(rows[i].ediff));
      check_output($sformatf("r%0d_size", i), 32'(dl_point_size), 32'(rows[i].size));
      @(negedge clk);
      check_output($sformatf("r%0d_end_frame", i), 32'(dl_end_frame), 32'd1);
      check_output($sformatf("r%0d_enable_off", i), 32'(dl_enable), 32'd0);
      wait_idle(n);
      check_output($sformatf("r%0d_latency", i), 32'(n), 32'(rows[i].ewait));
      exp_seg++;
      check_output($sformatf("r%0d_seg", i), 32'(seg_count), 32'(exp_seg));
      check_output($sformatf("r%0d_drop", i), 32'(drop_count), 32'(rows[i].edrop));
      check_output($sformatf("r%0d_npx", i), 32'(pix_q.size() - base), 32'(rows[i].enpx));
      if (rows[i].enpx == 1 && pix_q.size() > base)
        check_output($sformatf("r%0d_pix", i), 32'(pix_q[base]), 32'(pix(rows[i].x, rows[i].y)));
    end
    exp_drop = 2;

    // Continuing segment: five stepped pixels, four renews.
    set_single(10'd100, 10'd50);
    apply_stimulus(10'd100, 10'd50, 1'b1, 4'd4);
    wait_idle(n);
    exp_seg++;
    clear_path();
    for (int i = 0; i < 5; i++) begin
      path_x[i]    = 10'(100 + i);
      path_y[i]    = 10'(50 + i);
      path_done[i] = (i == 4);
    end
    base = pix_q.size();
    r0   = renew_cnt;
    apply_stimulus(10'd104, 10'd54, 1'b0, 4'd4);
    @(negedge clk);
    check_output("cont_x1", 32'(dl_x1), 32'd100);
    check_output("cont_y1", 32'(dl_y1), 32'd50);
    check_output("cont_diff", 32'(dl_different_line), 32'd0);
    wait_idle(n);
    exp_seg++;
    check_output("cont_npx", 32'(pix_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (pix_q.size() > base + i)
        check_output($sformatf("cont_pix%0d", i), 32'(pix_q[base + i]),
                     32'(pix(10'(100 + i), 10'(50 + i))));
    check_output("cont_renews", 32'(renew_cnt - r0), 32'd4);
    check_output("cont_seg", 32'(seg_count), 32'(exp_seg));

    // Backpressure: stall the second pixel for seven cycles.
    clear_path();
    for (int i = 0; i < 4; i++) begin
      path_x[i]    = 10'(200 + i);
      path_y[i]    = 10'd100;
      path_done[i] = (i == 3);
    end
    base = pix_q.size();
    r0   = renew_cnt;
    apply_stimulus(10'd203, 10'd100, 1'b1, 4'd2);
    wait_px_valid("bp_second_px", base + 1);
    px_ready = 1'b0;
    r0 = renew_cnt;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      check_output($sformatf("bp_valid%0d", k), 32'(px_valid), 32'd1);
      check_output($sformatf("bp_x%0d", k), 32'(px_x), 32'd201);
      check_output($sformatf("bp_y%0d", k), 32'(px_y), 32'd100);
      check_output($sformatf("bp_norenew%0d", k), 32'(renew_cnt - r0), 32'd0);
    end
    @(negedge clk);
    px_ready = 1'b1;
    wait_idle(n);
    exp_seg++;
    check_output("bp_npx", 32'(pix_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (pix_q.size() > base + i)
        check_output($sformatf("bp_pix%0d", i), 32'(pix_q[base + i]),
                     32'(pix(10'(200 + i), 10'd100)));

    // Filter and de-duplication.
    clear_path();
    path_x[0] = 10'd800; path_y[0] = 10'd10;
    path_x[1] = 10'd5;   path_y[1] = 10'd5;
    path_x[2] = 10'd5;   path_y[2] = 10'd5;   path_done[2] = 1'b1;
    base = pix_q.size();
    apply_stimulus(10'd5, 10'd5, 1'b1, 4'd1);
    wait_idle(n);
    exp_seg++;
    exp_drop++;
    check_output("dd_drop", 32'(drop_count), 32'(exp_drop));
    check_output("dd_npx", 32'(pix_q.size() - base), 32'd1);
    if (pix_q.size() > base)
      check_output("dd_pix", 32'(pix_q[base]), 32'(pix(10'd5, 10'd5)));
    check_output("dd_seg", 32'(seg_count), 32'(exp_seg));
    check_output("pre_wd_timeout", 32'(timeout_err), 32'd0);

    // Watchdog: drawer never finishes, limit is eight steps.
    clear_path();
    for (int i = 0; i < 32; i++) begin
      path_x[i] = 10'(300 + i);
      path_y[i] = 10'd20;
    end
    base = pix_q.size();
    r0   = renew_cnt;
    apply_stimulus(10'd300, 10'd20, 1'b1, 4'd0);
    wait_idle(n);
    exp_seg++;
    check_output("wd_timeout", 32'(timeout_err), 32'd1);
    check_output("wd_renews", 32'(renew_cnt - r0), 32'd8);
    check_output("wd_npx", 32'(pix_q.size() - base), 32'd9);
    if (pix_q.size() > base + 8)
      check_output("wd_last_pix", 32'(pix_q[base + 8]), 32'(pix(10'd308, 10'd20)));
    check_output("wd_busy", 32'(busy), 32'd0);
    check_output("wd_seg", 32'(seg_count), 32'(exp_seg));

    // Abort during WRITE.
    clear_path();
    path_x[0] = 10'd50; path_y[0] = 10'd50;
    path_x[1] = 10'd51; path_y[1] = 10'd51; path_done[1] = 1'b1;
    px_ready = 1'b0;
    base = pix_q.size();
    apply_stimulus(10'd51, 10'd51, 1'b0, 4'd7);
    wait_px_valid("ab_in_write", base);
    abort = 1'b1;
    #1;
    check_output("ab_px_valid_now", 32'(px_valid), 32'd0);
    check_output("ab_renew_now", 32'(dl_renew), 32'd0);
    @(negedge clk);
    abort    = 1'b0;
    px_ready = 1'b1;
    #1;
    check_output("ab_px_valid_next", 32'(px_valid), 32'd0);
    check_output("ab_busy", 32'(busy), 32'd0);
    check_output("ab_seg", 32'(seg_count), 32'(exp_seg));
    check_output("ab_no_pix", 32'(pix_q.size() - base), 32'd0);

    // Abort in IDLE blocks a simultaneous point.
    @(negedge clk);
    pt_x = 10'd9; pt_y = 10'd9; pt_new_stroke = 1'b0; pt_valid = 1'b1; abort = 1'b1;
    #1 check_output("ab_idle_ready", 32'(pt_ready), 32'd0);
    @(negedge clk);
    check_output("ab_idle_busy", 32'(busy), 32'd0);
    pt_valid = 1'b0;
    abort    = 1'b0;

    // The first point after an abort begins a new stroke.
    set_single(10'd60, 10'd60);
    apply_stimulus(10'd60, 10'd60, 1'b0, 4'd3);
    @(negedge clk);
    check_output("post_ab_diff", 32'(dl_different_line), 32'd1);
    check_output("post_ab_x1", 32'(dl_x1), 32'd60);
    check_output("post_ab_y1", 32'(dl_y1), 32'd60);
    wait_idle(n);
    exp_seg++;
    check_output("post_ab_seg", 32'(seg_count), 32'(exp_seg));

    check_output("pulse_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
